ahb_lite_master: RTL and testbench

//  AHB-Lite initiator: turns a simple valid/ready request port into single AHB transfers
//  (NONSEQ, HBURST=SINGLE) and returns read data and an error flag on a response port.

---
 rtl/ahb_lite_master.sv | 163 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: one request in, one NONSEQ/SINGLE transfer out, one response back.
// Optional HREADY-low watchdog is compiled in with `define AHB_MST_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        out_of_reset;
    logic [31:0] wdata_q;
    logic        req_legal;
    logic        accept;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // req_ready stays low through reset and rises on the first edge after release.
    assign req_ready = out_of_reset && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        case (req_size)
            3'd0:    req_legal = 1'b1;
            3'd1:    req_legal = ~req_addr[0];
            3'd2:    req_legal = (req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

`ifdef AHB_MST_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;

    // Counts consecutive HREADY-low cycles inside one bus state; any state change restarts it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if ((state == S_ADDR || state == S_DATA) && !HREADY) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == S_ADDR || state == S_DATA) && !HREADY && (wait_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no latch is inferred.
        state_next = state;
        HTRANS     = HTRANS_IDLE;
        case (state)
            S_IDLE: begin
                if (accept) state_next = req_legal ? S_ADDR : S_RESP;
            end
            S_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                if (HREADY)           state_next = S_DATA;
                else if (timeout_hit) state_next = S_RESP;
            end
            S_DATA: begin
                if (HREADY || timeout_hit) state_next = S_RESP;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= S_IDLE;
            out_of_reset <= 1'b0;
            HADDR        <= '0;
            HWRITE       <= 1'b0;
            HSIZE        <= '0;
            HWDATA       <= '0;
            wdata_q      <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state        <= state_next;
            out_of_reset <= 1'b1;
            case (state)
                S_IDLE: begin
                    // Address signals only move for legal requests so HADDR never toggles without a transfer.
                    if (accept && req_legal) begin
                        HADDR   <= req_addr;
                        HWRITE  <= req_write;
                        HSIZE   <= req_size;
                        wdata_q <= req_wdata;
                    end else if (accept) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        if (HWRITE) HWDATA <= wdata_q;
                    end else if (timeout_hit) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        rsp_err   <= HRESP;
                        rsp_rdata <= (!HWRITE && !HRESP) ? HRDATA : 32'h0;
                    end else if (timeout_hit) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: behavioural AHB slave with configurable wait/error, response and bus scoreboards.
// Build with +define+AHB_MST_TIMEOUT_EN to exercise the watchdog path (TIMEOUT_CYCLES=4).
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [2:0]  req_size  = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int nonseq_seen = 0;

    // Slave configuration
    int          cfg_addr_wait = 0;
    int          cfg_data_wait = 0;
    logic        cfg_err   = 1'b0;
    logic        cfg_fixed = 1'b1;
    logic [31:0] cfg_rdata = '0;

    // Slave state
    logic        s_in_data = 1'b0;
    int          s_acnt = 0;
    int          s_dcnt = 0;
    logic [31:0] s_addr = '0;
    bus_t        s_cur;
    logic        f_addr_done = 1'b0, f_addr_wait = 1'b0, f_data_done = 1'b0, f_data_wait = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (s_in_data) begin
            HREADY = (s_dcnt >= cfg_data_wait);
            HRESP  = cfg_err && (s_dcnt + 1 >= cfg_data_wait);
        end else if (HTRANS == 2'b10) begin
            HREADY = (s_acnt >= cfg_addr_wait);
        end
        HRDATA = cfg_fixed ? cfg_rdata : (s_addr ^ 32'h5A5A_0000);
    end

    // Slave decides mid-cycle what the coming edge does and checks the bus it sees.
    always @(negedge HCLK) begin
        f_addr_done = HRESETn && !s_in_data && (HTRANS == 2'b10) && HREADY;
        f_addr_wait = HRESETn && !s_in_data && (HTRANS == 2'b10) && !HREADY;
        f_data_done = HRESETn && s_in_data && HREADY;
        f_data_wait = HRESETn && s_in_data && !HREADY;
        if (f_addr_done) begin
            n_checks++;
            if (bus_q.size() == 0) begin
                n_fails++;
                $display("FAIL bus_unexpected: NONSEQ to %h completed, no transfer expected", HADDR);
            end else begin
                s_cur  = bus_q.pop_front();
                s_addr = s_cur.addr;
                if ({HADDR, HWRITE, HSIZE} !== {s_cur.addr, s_cur.write, s_cur.size}) begin
                    n_fails++;
                    $display("FAIL bus_addr_phase: got addr=%h wr=%b size=%0d, want addr=%h wr=%b size=%0d",
                             HADDR, HWRITE, HSIZE, s_cur.addr, s_cur.write, s_cur.size);
                end
            end
        end
        if (f_data_done && s_cur.write) begin
            n_checks++;
            if (HWDATA !== s_cur.wdata) begin
                n_fails++;
                $display("FAIL bus_hwdata: got %h, want %h", HWDATA, s_cur.wdata);
            end
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_in_data <= 1'b0;
            s_acnt    <= 0;
            s_dcnt    <= 0;
        end else begin
            if (f_addr_done) begin
                s_in_data <= 1'b1;
                s_acnt    <= 0;
            end else if (f_addr_wait) begin
                s_acnt <= s_acnt + 1;
            end else begin
                s_acnt <= 0;
            end
            if (f_data_done) begin
                s_in_data <= 1'b0;
                s_dcnt    <= 0;
            end else if (f_data_wait) begin
                s_dcnt <= s_dcnt + 1;
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    always @(negedge HCLK) begin
        rsp_t e;
        int   lat_obs;
        if (HRESETn) begin
            if (HTRANS == 2'b10) nonseq_seen++;
            if (rsp_valid) begin
                n_checks++;
                if (rsp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL rsp_unexpected: rsp_valid at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e = rsp_q.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_fails++;
                        $display("FAIL rsp_data: got rdata=%h err=%b, want rdata=%h err=%b",
                                 rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                    lat_obs = cyc - e.acc + 1;
                    if (e.lat >= 0) begin
                        n_checks++;
                        if (lat_obs != e.lat) begin
                            n_fails++;
                            $display("FAIL rsp_latency: got cycle %0d, want cycle %0d", lat_obs, e.lat);
                        end
                    end
                end
            end
        end
    end

    // Drives one request, returns #1 after its accepting edge (i.e. in cycle 1).
    task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int lat, input logic on_bus);
        int budget = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        @(negedge HCLK);
        while (!req_ready && budget < 300) begin
            @(negedge HCLK);
            budget++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL req_accept: request to %h not accepted within 300 cycles", a);
            req_valid = 1'b0;
            return;
        end
        @(posedge HCLK);
        #1;
        rsp_q.push_back('{rdata: exp_rd, err: exp_err, acc: cyc, lat: lat});
        if (on_bus) bus_q.push_back('{addr: a, write: w, size: sz, wdata: wd});
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (rsp_q.size() != 0 && budget < 300) begin
            step();
            budget++;
        end
        n_checks++;
        if (rsp_q.size() != 0) begin
            n_fails++;
            $display("FAIL rsp_drain: %0d responses still outstanding, want 0", rsp_q.size());
            rsp_q.delete();
            bus_q.delete();
        end
        step();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        #2;
        n_checks++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA} !== '0) begin
            n_fails++;
            $display("FAIL reset_bus: got trans=%b addr=%h wr=%b size=%0d wdata=%h, want all 0",
                     HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
        end
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            n_fails++;
            $display("FAIL reset_req_rsp: got ready=%b valid=%b rdata=%h err=%b, want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        n_checks++;
        if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_constants: got burst=%b prot=%b lock=%b, want 000 0011 0",
                     HBURST, HPROT, HMASTLOCK);
        end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_ready_before_edge: got %b, want 0", req_ready);
        end
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ready_after_edge: got %b, want 1", req_ready);
        end
    endtask

    task automatic test_zero_wait_read();
        cfg_addr_wait = 0; cfg_data_wait = 0; cfg_fixed = 1'b1; cfg_rdata = 32'hDEAD_BEEF;
        do_req(1'b0, 32'h0000_0104, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
        n_checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0104 || HWRITE !== 1'b0 || HSIZE !== 3'd2) begin
            n_fails++;
            $display("FAIL read_cycle1: got trans=%b addr=%h wr=%b size=%0d, want 10 00000104 0 2",
                     HTRANS, HADDR, HWRITE, HSIZE);
        end
        step();
        n_checks++;
        if (HTRANS !== 2'b00) begin
            n_fails++;
            $display("FAIL read_cycle2_trans: got %b, want 00", HTRANS);
        end
        wait_done();
        n_checks++;
        if (HADDR !== 32'h0000_0104) begin
            n_fails++;
            $display("FAIL read_haddr_hold: got %h, want 00000104", HADDR);
        end
    endtask

    task automatic test_write_wait();
        cfg_data_wait = 2;
        do_req(1'b1, 32'h2000_0000, 3'd2, 32'h1234_5678, 32'h0, 1'b0, 5, 1'b1);
        for (int c = 2; c <= 4; c++) begin
            step();
            n_checks++;
            if (HWDATA !== 32'h1234_5678 || HTRANS !== 2'b00) begin
                n_fails++;
                $display("FAIL write_data_phase_c%0d: got wdata=%h trans=%b, want 12345678 00", c, HWDATA, HTRANS);
            end
        end
        wait_done();
        cfg_data_wait = 0;
        n_checks++;
        if (HWDATA !== 32'h1234_5678) begin
            n_fails++;
            $display("FAIL write_hwdata_hold: got %h, want 12345678", HWDATA);
        end
    endtask

    task automatic test_error_read();
        cfg_data_wait = 1; cfg_err = 1'b1; cfg_rdata = 32'hCAFE_F00D;
        do_req(1'b0, 32'h0000_0030, 3'd2, 32'h0, 32'h0, 1'b1, 4, 1'b1);
        for (int c = 2; c <= 3; c++) begin
            step();
            n_checks++;
            if (HTRANS !== 2'b00) begin
                n_fails++;
                $display("FAIL error_trans_c%0d: got %b, want 00", c, HTRANS);
            end
        end
        wait_done();
        cfg_data_wait = 0; cfg_err = 1'b0;
    endtask

    task automatic test_illegal();
        int          ns0;
        logic [31:0] haddr0;
        ns0    = nonseq_seen;
        haddr0 = HADDR;
        do_req(1'b0, 32'h0000_0102, 3'd2, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        wait_done();
        do_req(1'b1, 32'h0000_0100, 3'd3, 32'h5555_AAAA, 32'h0, 1'b1, 1, 1'b0);
        wait_done();
        do_req(1'b0, 32'h0000_0201, 3'd1, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        wait_done();
        n_checks++;
        if (nonseq_seen != ns0 || HADDR !== haddr0) begin
            n_fails++;
            $display("FAIL illegal_no_bus: got %0d NONSEQ cycles haddr=%h, want 0 cycles haddr=%h",
                     nonseq_seen - ns0, HADDR, haddr0);
        end
    endtask

    task automatic test_reset_mid();
        cfg_data_wait = 1000;
        do_req(1'b0, 32'h0000_0500, 3'd2, 32'h0, 32'h0, 1'b0, -1, 1'b1);
        step();
        n_checks++;
        if (HTRANS !== 2'b00 || HREADY !== 1'b0) begin
            n_fails++;
            $display("FAIL midreset_in_data: got trans=%b hready=%b, want 00 0", HTRANS, HREADY);
        end
        #1;
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({HTRANS, HADDR, HWDATA, req_ready, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            n_fails++;
            $display("FAIL midreset_outputs: got trans=%b addr=%h wdata=%h ready=%b valid=%b err=%b rdata=%h, want 0",
                     HTRANS, HADDR, HWDATA, req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_q.delete();
        bus_q.delete();
        cfg_data_wait = 0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (5) step();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL midreset_ready: got %b, want 1", req_ready);
        end
        cfg_fixed = 1'b0;
        do_req(1'b0, 32'h0000_0600, 3'd2, 32'h0, 32'h5A5A_0600, 1'b0, 3, 1'b1);
        wait_done();
    endtask

    task automatic test_timeout();
        logic ok = 1'b1;
        cfg_fixed = 1'b0;
        cfg_addr_wait = 1_000_000;
`ifdef AHB_MST_TIMEOUT_EN
        do_req(1'b0, 32'h0000_0040, 3'd2, 32'h0, 32'h0, 1'b1, 5, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            n_checks++;
            if (HTRANS !== 2'b10) begin
                n_fails++;
                $display("FAIL timeout_nonseq_c%0d: got %b, want 10", c, HTRANS);
            end
        end
        step();
        n_checks++;
        if (HTRANS !== 2'b00 || rsp_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_abort: got trans=%b rsp_valid=%b, want 00 1", HTRANS, rsp_valid);
        end
        cfg_addr_wait = 0;
        wait_done();
`else
        do_req(1'b0, 32'h0000_0040, 3'd2, 32'h0, 32'h5A5A_0040, 1'b0, -1, 1'b1);
        for (int c = 0; c < 100; c++) begin
            if (HTRANS !== 2'b10 || rsp_valid !== 1'b0) ok = 1'b0;
            step();
        end
        n_checks++;
        if (!ok || HTRANS !== 2'b10) begin
            n_fails++;
            $display("FAIL notimeout_wait: got trans=%b after 100 cycles, want 10 with no rsp_valid", HTRANS);
        end
        cfg_addr_wait = 0;
        wait_done();
`endif
    endtask

    task automatic test_back_to_back();
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        cfg_fixed = 1'b0; cfg_addr_wait = 0; cfg_data_wait = 1;
        for (int i = 0; i < 10; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 2));
            a  = $urandom & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            if (i == 4) begin
                do_req(w, a | 32'd1, 3'd1, wd, 32'h0, 1'b1, 1, 1'b0);
            end else begin
                do_req(w, a, sz, wd, w ? 32'h0 : (a ^ 32'h5A5A_0000), 1'b0, 4, 1'b1);
            end
        end
        wait_done();
        cfg_data_wait = 0;
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_error_read();
        test_illegal();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
